pool_wb_sched: RTL and testbench

//   Write-back scheduler for the pooling engine. Takes the gathered PPU beats (S*R bytes each),

---
 rtl/pool_wb_sched.sv | 101 ++++++++++
 tb/tb_pool_wb_sched.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pool_wb_sched.sv
// pool_wb_sched: tags pooled PPU beats with 2-D RTM addresses, buffers them in a FWFT FIFO,
// drains them under RTM backpressure, throttles the PPUs and reports instruction completion.
module pool_wb_sched #(
  parameter int DATA_W     = 1024,
  parameter int ADDR_W     = 16,
  parameter int LEN_W      = 16,
  parameter int FIFO_DEPTH = 16,
  parameter int AF_MARGIN  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  n_beats,
  input  logic [LEN_W-1:0]  row_beats,
  input  logic [ADDR_W-1:0] row_stride,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_vld,
  output logic              stall,
  output logic              rtm_wr_en,
  output logic [ADDR_W-1:0] rtm_wr_addr,
  output logic [DATA_W-1:0] rtm_wr_data,
  input  logic              rtm_wr_rdy,
  output logic              busy,
  output logic              done,
  output logic              err
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int EW = ADDR_W + DATA_W;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state_q, state_d;
  logic [EW-1:0] mem_q [FIFO_DEPTH];
  logic [EW-1:0] head;
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PW:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] n_q, row_beats_q, col_q, beats_q;
  logic [ADDR_W-1:0] stride_q, row_base_q;
  logic busy_q, done_q, stall_q, err_q;
  logic full, pop, push, drop, last, accept;
  assign full   = cnt_q == (PW+1)'(FIFO_DEPTH);
  assign pop    = cnt_q != '0 && rtm_wr_rdy;
  assign push   = state_q == RUN && in_vld && (!full || pop);
  assign drop   = in_vld && !push;
  assign last   = beats_q == n_q - 1'b1;
  assign accept = state_q == IDLE && start;
  assign cnt_d  = cnt_q + (PW+1)'(push) - (PW+1)'(pop);
  assign head   = mem_q[rd_ptr_q];
  always_comb
    state_d = state_q == IDLE  ? (start ? (n_beats == '0 ? DONE : RUN) : IDLE) :
              state_q == RUN   ? (push && last ? DRAIN : RUN) :
              state_q == DRAIN ? (cnt_q == '0 ? DONE : DRAIN) : IDLE;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      n_q         <= '0;
      row_beats_q <= '0;
      col_q       <= '0;
      beats_q     <= '0;
      stride_q    <= '0;
      row_base_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      stall_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= state_d != IDLE;
      done_q  <= state_d == DONE;
      stall_q <= state_d != IDLE && cnt_d >= (PW+1)'(FIFO_DEPTH - AF_MARGIN);
      err_q   <= drop || (err_q && !accept);
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      if (accept) begin
        n_q         <= n_beats;
        row_beats_q <= row_beats;
        stride_q    <= row_stride;
        row_base_q  <= base_addr;
        col_q       <= '0;
        beats_q     <= '0;
      end else if (push) begin
        beats_q <= beats_q + 1'b1;
        col_q   <= col_q == row_beats_q - 1'b1 ? '0 : col_q + 1'b1;
        if (col_q == row_beats_q - 1'b1) row_base_q <= row_base_q + stride_q;
      end
    end
  end
  // Payload storage needs no reset: visibility is governed by cnt_q alone.
  always_ff @(posedge clk)
    if (push) mem_q[wr_ptr_q] <= {row_base_q + ADDR_W'(col_q), in_data};
  assign rtm_wr_en   = cnt_q != '0;
  assign rtm_wr_addr = rtm_wr_en ? head[EW-1:DATA_W] : '0;
  assign rtm_wr_data = rtm_wr_en ? head[DATA_W-1:0] : '0;
  assign stall       = stall_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;
endmodule

// File: tb/tb_pool_wb_sched.sv
// tb_pool_wb_sched: directed scenarios for the pooling write-back scheduler.
module tb_pool_wb_sched;
  localparam int DW = 1024;
  localparam int AW = 16;
  localparam int LW = 16;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, in_vld = 1'b0, rtm_wr_rdy = 1'b0;
  logic [AW-1:0] base_addr = '0, row_stride = '0;
  logic [LW-1:0] n_beats = '0, row_beats = 16'd1;
  logic [DW-1:0] in_data = '0;
  logic stall, rtm_wr_en, busy, done, err;
  logic [AW-1:0] rtm_wr_addr;
  logic [DW-1:0] rtm_wr_data;
  int pass_cnt = 0, total = 0, done_cnt = 0;
  logic [AW-1:0] got_addr[$];
  logic [DW-1:0] got_data[$];

  pool_wb_sched dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .n_beats(n_beats),
    .row_beats(row_beats), .row_stride(row_stride), .in_data(in_data), .in_vld(in_vld),
    .stall(stall), .rtm_wr_en(rtm_wr_en), .rtm_wr_addr(rtm_wr_addr), .rtm_wr_data(rtm_wr_data),
    .rtm_wr_rdy(rtm_wr_rdy), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst_n && rtm_wr_en && rtm_wr_rdy) begin
      got_addr.push_back(rtm_wr_addr);
      got_data.push_back(rtm_wr_data);
    end
    if (done === 1'b1) done_cnt++;
  end

  function automatic logic [DW-1:0] pat(int k);
    return {32{32'hA5000000 ^ 32'(k)}};
  endfunction

  function automatic logic [AW-1:0] exp_addr(int base, int rb, int stride, int i);
    return AW'(base + (i / rb) * stride + (i % rb));
  endfunction

  // Index of the first transfer that differs from the address/data model, n if the count is wrong, -1 if all match.
  function automatic int first_bad(int base, int rb, int stride, int k0, int n);
    if (got_addr.size() != n) return n;
    for (int i = 0; i < n; i++)
      if (got_addr[i] !== exp_addr(base, rb, stride, i) || got_data[i] !== pat(k0 + i)) return i;
    return -1;
  endfunction

  task automatic start_instr(int base, int n, int rb, int stride);
    @(negedge clk);
    base_addr = AW'(base); n_beats = LW'(n); row_beats = LW'(rb); row_stride = AW'(stride);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic feed(int k0, int n);
    for (int i = 0; i < n; i++) begin
      in_vld = 1'b1;
      in_data = pat(k0 + i);
      @(negedge clk);
    end
    in_vld = 1'b0;
  endtask

  task automatic wait_done(string nm, int budget);
    for (int c = 0; c < budget && done !== 1'b1; c++) @(negedge clk);
    total++;
    if (done !== 1'b1) $display("FAIL %s_done_timeout got done=%b exp 1", nm, done);
    else pass_cnt++;
    @(negedge clk);
  endtask

  task automatic test_reset;
    total++;
    if ({busy, done, stall, rtm_wr_en, err, rtm_wr_addr, |rtm_wr_data} !== '0)
      $display("FAIL reset_outputs got busy=%b done=%b stall=%b en=%b err=%b exp all 0",
               busy, done, stall, rtm_wr_en, err);
    else pass_cnt++;
  endtask

  task automatic test_basic;
    int dc0, idx;
    rtm_wr_rdy = 1'b1;
    got_addr.delete(); got_data.delete();
    dc0 = done_cnt;
    start_instr(32'h100, 8, 4, 32'h40);
    in_vld = 1'b1; in_data = pat(0);
    @(negedge clk);
    total++;
    if (rtm_wr_en !== 1'b1 || rtm_wr_addr !== 16'h0100)
      $display("FAIL basic_latency got en=%b addr=%h exp en=1 addr=0100", rtm_wr_en, rtm_wr_addr);
    else pass_cnt++;
    for (int i = 1; i < 8; i++) begin
      in_data = pat(i);
      @(negedge clk);
    end
    in_vld = 1'b0;
    wait_done("basic", 40);
    idx = first_bad(32'h100, 4, 32'h40, 0, 8);
    total++;
    if (idx !== -1) $display("FAIL basic_order got bad index %0d of %0d transfers exp -1", idx, got_addr.size());
    else pass_cnt++;
    total++;
    if (done_cnt - dc0 !== 1 || err !== 1'b0 || busy !== 1'b0)
      $display("FAIL basic_end got dones=%0d err=%b busy=%b exp 1 0 0", done_cnt - dc0, err, busy);
    else pass_cnt++;
  endtask

  task automatic test_stall;
    int dc0, idx;
    rtm_wr_rdy = 1'b0;
    got_addr.delete(); got_data.delete();
    dc0 = done_cnt;
    start_instr(32'h100, 8, 4, 32'h40);
    feed(0, 7);
    total++;
    if (stall !== 1'b0) $display("FAIL stall_at7 got %b exp 0", stall);
    else pass_cnt++;
    feed(7, 1);
    total++;
    if (stall !== 1'b1) $display("FAIL stall_at8 got %b exp 1", stall);
    else pass_cnt++;
    repeat (11) @(negedge clk);
    total++;
    if (done_cnt != dc0 || busy !== 1'b1 || rtm_wr_en !== 1'b1 || got_addr.size() != 0)
      $display("FAIL stall_hold got dones=%0d busy=%b en=%b xfers=%0d exp 0 1 1 0",
               done_cnt - dc0, busy, rtm_wr_en, got_addr.size());
    else pass_cnt++;
    rtm_wr_rdy = 1'b1;
    for (int c = 0; c < 40 && done !== 1'b1; c++) @(negedge clk);
    total++;
    if (done !== 1'b1 || got_addr.size() != 8)
      $display("FAIL stall_done_after_last got done=%b xfers=%0d exp 1 8", done, got_addr.size());
    else pass_cnt++;
    @(negedge clk);
    idx = first_bad(32'h100, 4, 32'h40, 0, 8);
    total++;
    if (idx !== -1 || err !== 1'b0 || stall !== 1'b0)
      $display("FAIL stall_order got bad index %0d err=%b stall=%b exp -1 0 0", idx, err, stall);
    else pass_cnt++;
  endtask

  task automatic test_overflow;
    int idx;
    rtm_wr_rdy = 1'b0;
    got_addr.delete(); got_data.delete();
    start_instr(32'h200, 20, 20, 0);
    feed(100, 16);
    total++;
    if (stall !== 1'b1 || err !== 1'b0) $display("FAIL ovf_full got stall=%b err=%b exp 1 0", stall, err);
    else pass_cnt++;
    in_vld = 1'b1; in_data = pat(999);
    @(negedge clk);
    in_vld = 1'b0;
    total++;
    if (err !== 1'b1) $display("FAIL ovf_err got %b exp 1", err);
    else pass_cnt++;
    rtm_wr_rdy = 1'b1;
    for (int c = 0; c < 40 && rtm_wr_en === 1'b1; c++) @(negedge clk);
    total++;
    if (got_addr.size() != 16 || busy !== 1'b1 || done !== 1'b0)
      $display("FAIL ovf_count got xfers=%0d busy=%b done=%b exp 16 1 0", got_addr.size(), busy, done);
    else pass_cnt++;
    feed(116, 4);
    wait_done("ovf", 40);
    idx = first_bad(32'h200, 20, 0, 100, 20);
    total++;
    if (idx !== -1 || err !== 1'b1)
      $display("FAIL ovf_order got bad index %0d err=%b exp -1 1", idx, err);
    else pass_cnt++;
  endtask

  task automatic test_zero;
    got_addr.delete(); got_data.delete();
    start_instr(32'h1234, 0, 1, 0);
    total++;
    if (done !== 1'b1 || err !== 1'b0 || rtm_wr_en !== 1'b0 || busy !== 1'b1)
      $display("FAIL zero_done got done=%b err=%b en=%b busy=%b exp 1 0 0 1", done, err, rtm_wr_en, busy);
    else pass_cnt++;
    @(negedge clk);
    total++;
    if (done !== 1'b0 || busy !== 1'b0 || got_addr.size() != 0)
      $display("FAIL zero_after got done=%b busy=%b xfers=%0d exp 0 0 0", done, busy, got_addr.size());
    else pass_cnt++;
  endtask

  task automatic test_reset_mid;
    int dc0, idx;
    rtm_wr_rdy = 1'b0;
    start_instr(32'h300, 8, 4, 32'h10);
    feed(200, 5);
    total++;
    if (rtm_wr_en !== 1'b1 || busy !== 1'b1)
      $display("FAIL rstmid_pre got en=%b busy=%b exp 1 1", rtm_wr_en, busy);
    else pass_cnt++;
    dc0 = done_cnt;
    rst_n = 1'b0;
    @(negedge clk);
    total++;
    if ({busy, done, stall, rtm_wr_en, err, rtm_wr_addr, |rtm_wr_data} !== '0)
      $display("FAIL rstmid_outputs got busy=%b done=%b stall=%b en=%b err=%b exp all 0",
               busy, done, stall, rtm_wr_en, err);
    else pass_cnt++;
    rst_n = 1'b1;
    rtm_wr_rdy = 1'b1;
    got_addr.delete(); got_data.delete();
    start_instr(32'h500, 4, 2, 32'h100);
    feed(300, 4);
    wait_done("rstmid", 40);
    idx = first_bad(32'h500, 2, 32'h100, 300, 4);
    total++;
    if (idx !== -1 || done_cnt - dc0 != 1)
      $display("FAIL rstmid_restart got bad index %0d dones=%0d exp -1 1", idx, done_cnt - dc0);
    else pass_cnt++;
  endtask

  task automatic test_wrap;
    int idx;
    rtm_wr_rdy = 1'b1;
    got_addr.delete(); got_data.delete();
    start_instr(32'hFFFE, 4, 4, 32'h40);
    feed(400, 4);
    wait_done("wrap", 40);
    idx = first_bad(32'hFFFE, 4, 32'h40, 400, 4);
    total++;
    if (idx !== -1 || got_addr.size() != 4 || got_addr[2] !== 16'h0000)
      $display("FAIL wrap_addr got bad index %0d xfers=%0d exp -1 4 (FFFE FFFF 0000 0001)", idx, got_addr.size());
    else pass_cnt++;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_basic();
    test_stall();
    test_overflow();
    test_zero();
    test_reset_mid();
    test_wrap();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
